// File: rtl/tt_and_drv_pkg.sv
// Shared types and constants for the tt_um_and stimulus driver/checker.
package tt_and_drv_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} drv_state_t;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Right-shift Galois step; feedback taps come from LFSR_POLY.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/tt_and_drv_lfsr.sv
// 16-bit Galois LFSR with load/advance/enable. A zero seed would lock the
// register at zero, so it is replaced by LFSR_DEFAULT_SEED on load.
module tt_and_drv_lfsr
    import tt_and_drv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] nxt
);

    logic [15:0] value;

    // nxt is the value the register takes at the coming enabled edge; the
    // top loads its operand registers from it so a/b track the LFSR.
    always_comb begin
        nxt = value;
        if (load)
            nxt = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        else if (advance)
            nxt = lfsr_step(value);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= LFSR_DEFAULT_SEED;
        else if (en)
            value <= nxt;
    end

endmodule

// File: rtl/tt_um_and_driver.sv
// Stimulus driver and checker for the tt_um_and core. Define
// TT_AND_DRV_CHECK_EN to build the y-vs-(a&b) comparator and err_count.
module tt_um_and_driver
    import tt_and_drv_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SETTLE  = 2,
    parameter int NUM_VEC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [7:0]       vec_count,
    output logic [7:0]       err_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    drv_state_t  state, state_n;
    logic [CW-1:0] settle_cnt;
    logic [15:0] lfsr_nxt;
    logic        load, advance, last_vec;

    assign load     = start && (state == IDLE || state == DONE);
    assign advance  = (state == SAMPLE);
    assign last_vec = (vec_count == 8'(NUM_VEC - 1));
    assign busy     = (state == APPLY) || (state == SAMPLE);
    assign done     = (state == DONE);

    tt_and_drv_lfsr u_lfsr (
        .clk     (clk),
        .rst     (reset),
        .en      (ena),
        .load    (load),
        .advance (advance),
        .seed    (seed),
        .nxt     (lfsr_nxt)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = APPLY;
            APPLY:      if (settle_cnt == CW'(SETTLE - 1)) state_n = SAMPLE;
            SAMPLE:     state_n = last_vec ? DONE : APPLY;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (ena)
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a          <= '0;
            b          <= '0;
            settle_cnt <= '0;
            vec_count  <= '0;
        end else if (ena) begin
            if (load) begin
                a          <= lfsr_nxt[15:8];
                b          <= lfsr_nxt[7:0];
                settle_cnt <= '0;
                vec_count  <= '0;
            end else if (state == APPLY) begin
                settle_cnt <= settle_cnt + CW'(1);
            end else if (state == SAMPLE) begin
                a          <= lfsr_nxt[15:8];
                b          <= lfsr_nxt[7:0];
                settle_cnt <= '0;
                vec_count  <= vec_count + 8'd1;
            end
        end
    end

`ifdef TT_AND_DRV_CHECK_EN
    logic mismatch;
    assign mismatch = (y != (a & b));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (ena) begin
            if (load)
                err_count <= '0;
            else if (state == SAMPLE && mismatch && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
`else
    logic unused;
    assign unused    = ^y;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_tt_um_and_driver.sv
// Directed bench for tt_um_and_driver with a cycle-level behavioural model.
module tb_tt_um_and_driver;

    localparam int S  = 2;
    localparam int NV = 2;
`ifdef TT_AND_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, ena = 1'b1, start = 1'b0, force_ff = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [7:0]  y, a, b, vec_count, err_count;
    logic        busy, done;
    int          tests = 0, fails = 0, cyc = 0, t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign y = force_ff ? 8'hFF : (a & b);

    tt_um_and_driver #(.WIDTH(8), .SETTLE(S), .NUM_VEC(NV)) dut (
        .clk(clk), .reset(reset), .ena(ena), .start(start), .seed(seed), .y(y),
        .a(a), .b(b), .busy(busy), .done(done),
        .vec_count(vec_count), .err_count(err_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lf_pow(input logic [15:0] s, input int n);
        logic [15:0] l = s;
        for (int i = 0; i < n; i++)
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        return l;
    endfunction

    // Model: a run is NV vectors of S+1 enabled cycles each, counted from the
    // cycle after start; vector i presents LFSR^i(seed), sampled in its last cycle.
    bit          m_run = 0, m_done = 0;
    int          m_k = 0, m_err = 0;
    logic [15:0] m_seed = 16'h0;

    always @(negedge clk) begin
        logic [15:0] l;
        int          idx, ev;
        l = 16'h0; idx = 0; ev = 0;
        if (reset) begin
            m_run = 0; m_done = 0; m_k = 0; m_err = 0;
        end
        if (m_run) begin
            idx = m_k / (S + 1);
            l   = lf_pow(m_seed, idx);
            ev  = idx;
        end else if (m_done) begin
            l  = lf_pow(m_seed, NV);
            ev = NV;
        end
        chk("a", a, l[15:8]);
        chk("b", b, l[7:0]);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("vec_count", vec_count, ev);
        chk("err_count", err_count, m_err);
        if (!reset && ena) begin
            if (m_run) begin
                if (m_k % (S + 1) == S && CHK && y != (l[15:8] & l[7:0]) && m_err < 255)
                    m_err++;
                m_k++;
                if (m_k == NV * (S + 1)) begin
                    m_run = 0; m_done = 1;
                end
            end else if (start) begin
                m_run = 1; m_done = 0; m_k = 0; m_err = 0;
                m_seed = (seed == 16'h0) ? 16'hACE1 : seed;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [15:0] s);
        seed = s; start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin tick(); n++; end
        if (!done) chk("done timeout", done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        chk("reset a", a, 8'h00);
        chk("reset busy", busy, 0);
        reset = 1'b0;
        tick();

        // Clean run from seed 1: (00,01) then (B4,00), a/b end at 5A00.
        pulse_start(16'h0001);
        chk("clean a0", a, 8'h00);
        chk("clean b0", b, 8'h01);
        chk("clean busy", busy, 1);
        repeat (3) tick();
        chk("clean a1", a, 8'hB4);
        chk("clean b1", b, 8'h00);
        chk("clean vec1", vec_count, 1);
        wait_done();
        chk("clean length", cyc - t0, 6);
        chk("clean vec", vec_count, 2);
        chk("clean err", err_count, 0);
        chk("clean final a", a, 8'h5A);

        // Fault: y stuck at FF, restarted straight from DONE.
        force_ff = 1'b1;
        pulse_start(16'h0001);
        wait_done();
        chk("fault err", err_count, CHK ? 2 : 0);
        force_ff = 1'b0;

        // Zero seed substitution.
        pulse_start(16'h0000);
        chk("zero seed a", a, 8'hAC);
        chk("zero seed b", b, 8'hE1);
        wait_done();

        // start while busy is ignored.
        pulse_start(16'h1234);
        tick();
        seed = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy start a", a, 8'h12);
        chk("busy start b", b, 8'h34);
        wait_done();
        chk("busy start length", cyc - t0, 6);

        // Asynchronous reset during the second vector.
        pulse_start(16'h0001);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        chk("async a", a, 8'h00);
        chk("async busy", busy, 0);
        chk("async vec", vec_count, 0);
        tick();
        reset = 1'b0;
        tick();
        pulse_start(16'h0001);
        wait_done();
        chk("after reset length", cyc - t0, 6);
        chk("after reset vec", vec_count, 2);

        // ena low for 3 cycles in APPLY stretches the run by 3.
        pulse_start(16'h0001);
        tick();
        ena = 1'b0;
        repeat (3) tick();
        ena = 1'b1;
        wait_done();
        chk("stall length", cyc - t0, 9);
        chk("stall vec", vec_count, 2);
        chk("stall err", err_count, 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tt_um_and_driver.md
# tt_um_and_driver

On-chip stimulus driver and checker for the `tt_um_and` core; it sits on the opposite side of the core's `a`/`b`/`Y` interface. It generates operand pairs from a 16-bit LFSR and drives them onto `a`/`b`. After a programmable settle time it samples `Y` and compares it against `a & b`, counting vectors and mismatches. It lets the tile self-test the AND core without external pattern equipment.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width (fixed at 8; LFSR supplies 2×8 bits)
- `SETTLE`, 2, cycles operands are held before `Y` is sampled (≥1)
- `NUM_VEC`, 16, vectors per run (1..255)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `ena`  in  1  global enable; low freezes all state
- `start`  in  1  run request (single-cycle pulse)
- `seed`  in  16  LFSR seed, sampled on accepted `start`
- `y`  in  WIDTH  result from core `Y`
- `a`  out  WIDTH  operand A to core (registered)
- `b`  out  WIDTH  operand B to core (registered)
- `busy`  out  1  run in progress
- `done`  out  1  run complete; level, held until next `start` or `reset`
- `vec_count`  out  8  vectors sampled this run
- `err_count`  out  8  mismatches this run, saturating at 255

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- LFSR update: right-shift Galois, `next = (l >> 1) ^ (l[0] ? 16'hB400 : 0)`.
- Operand mapping: `a = l[15:8]`, `b = l[7:0]`.
- Seed 0x0000 is replaced by 0xACE1.
- IDLE/DONE + `start` → APPLY:
  - load LFSR and `a`/`b` from the seed
  - clear `vec_count`, `err_count`, `done`
  - clear settle counter
- APPLY: settle counter increments each enabled cycle; after `SETTLE` cycles → SAMPLE.
- SAMPLE (one cycle):
  - compare `y` with `a & b`; `err_count`++ on mismatch, saturating
  - `vec_count`++
  - advance LFSR and reload `a`/`b`
  - if `vec_count` reaches `NUM_VEC` → DONE, else → APPLY with counter cleared
- DONE: `done`=1, `busy`=0; `a`/`b` hold the post-advance LFSR value.
- `start` while `busy` is ignored.
- `start` in DONE restarts immediately.
- `ena`=0 holds state, counters, LFSR and outputs; `start` is ignored while `ena`=0.

## Timing
- Reset values:
  - `a`=`b`=0, `busy`=0, `done`=0, `vec_count`=`err_count`=0
  - LFSR=0xACE1, state IDLE
- `start` accepted at cycle T:
  - `busy`=1 and the first operands are visible at T+1
  - first SAMPLE at T+SETTLE+1
- Per-vector period: SETTLE+1 cycles.
- Run length: `done` rises NUM_VEC×(SETTLE+1) cycles after T+1.
- `y` is sampled combinationally in SAMPLE; the core result must be valid within `SETTLE` cycles.
- `reset` mid-run: all outputs return to reset values asynchronously; state IDLE.
- Counters update on the SAMPLE clock edge and are visible the following cycle.

## Configuration
- Macro `TT_AND_DRV_CHECK_EN`.
- Defined: comparator and `err_count` logic present, as described above.
- Undefined:
  - comparator removed; `err_count` tied to 0
  - `y` unused and folded into the unused-signal reduction
  - `vec_count`, operand generation and FSM unchanged

## Structure
- Package `tt_and_drv_pkg`:
  - state enum `drv_state_t`
  - `LFSR_POLY` = 16'hB400
  - `LFSR_DEFAULT_SEED` = 16'hACE1
- Sub-module `tt_and_drv_lfsr`:
  - 16-bit Galois LFSR with load, advance and enable inputs
  - zero-seed substitution inside this module
- Top level: FSM, settle counter, `vec_count`/`err_count`, optional comparator.

## Test plan
- Reset: assert `reset` mid-cycle → `a`=`b`=0, `busy`=`done`=0, counts 0 without waiting for a clock edge.
- Clean run: `seed`=0x0001, `NUM_VEC`=2, `SETTLE`=2, `y`=`a & b` →
  - vectors (0x00,0x01) then (0xB4,0x00)
  - `done` rises 6 cycles after T+1
  - `vec_count`=2, `err_count`=0
- Fault detection: same run with `y` forced to 0xFF → `err_count`=2. With `TT_AND_DRV_CHECK_EN` undefined → `err_count`=0.
- Zero seed: `seed`=0x0000 → first operands `a`=0xAC, `b`=0xE1.
- Reset mid-run and busy-start: `start` pulsed during APPLY is ignored, run unchanged. `reset` during the 2nd vector → immediate IDLE with zeroed outputs; a new `start` runs cleanly.
- Enable stall: `ena` low for 3 cycles during APPLY → `done` delayed exactly 3 cycles; counts unchanged.
